// File: rtl/lsu_sequencer.sv
// Load/store sequencer between execute and the data-memory bus: one or two
// word-aligned beats per access, load merge/extension, pipeline stall.
module lsu_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_mem_r,
   input  logic              i_req_mem_w,
   input  logic [2:0]        i_req_funct3,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_stall,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_bus_valid,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [3:0]        o_bus_wstrb,
   output logic [31:0]       o_bus_wdata,
   input  logic              i_bus_ready,
   input  logic              i_bus_rvalid,
   input  logic [31:0]       i_bus_rdata
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_B0_REQ  = 3'd1,
      S_B0_WAIT = 3'd2,
      S_B1_REQ  = 3'd3,
      S_B1_WAIT = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   state_t            r_state;
   logic              r_we;
   logic              r_split;
   logic [1:0]        r_off;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr1;
   logic [31:0]       r_wdata_hi;
   logic [3:0]        r_wstrb_hi;
   logic [31:0]       r_rd0;
   logic              r_bus_valid;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [3:0]        r_bus_wstrb;
   logic [31:0]       r_bus_wdata;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [31:0]       r_rsp_rdata;

   logic              w_access;
   logic              w_accept;
   logic              w_illegal;
   logic              w_split;
   logic [ADDR_W-1:0] w_addr0;
   logic [3:0]        w_size_mask;
   logic [7:0]        w_strb8;
   logic [31:0]       w_wdata_lo;
   logic [31:0]       w_wdata_hi;
   logic [31:0]       w_rd_lo;
   logic [23:0]       w_rd_hi;
   logic [31:0]       w_stream;
   logic [31:0]       w_load;

   function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] f3);
      logic [31:0] v;
      case (f3)
         3'b000:  v = {{24{d[7]}}, d[7:0]};
         3'b001:  v = {{16{d[15]}}, d[15:0]};
         3'b010:  v = d;
         3'b100:  v = {24'd0, d[7:0]};
         3'b101:  v = {16'd0, d[15:0]};
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   assign o_req_ready = (r_state == S_IDLE);
   assign o_stall     = ((r_state != S_IDLE) && (r_state != S_RESP)) ||
                        ((r_state == S_IDLE) && i_req_valid && w_access);
   assign o_bus_valid = r_bus_valid;
   assign o_bus_we    = r_bus_we;
   assign o_bus_addr  = r_bus_addr;
   assign o_bus_wstrb = r_bus_wstrb;
   assign o_bus_wdata = r_bus_wdata;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_rdata = r_rsp_rdata;

   // Request decode: legality, access size, split detection, lane strobes.
   always_comb begin
      w_access = i_req_mem_r | i_req_mem_w;
      w_accept = i_req_valid & o_req_ready & w_access;
      w_addr0  = {i_req_addr[ADDR_W-1:2], 2'b00};
      if (i_req_mem_r && i_req_mem_w) begin
         w_illegal = 1'b1;
      end else if (i_req_mem_r) begin
         w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
      end else begin
         w_illegal = (i_req_funct3 > 3'b010);
      end
      case (i_req_funct3[1:0])
         2'b00: begin w_size_mask = 4'b0001; w_split = 1'b0; end
         2'b01: begin w_size_mask = 4'b0011; w_split = (i_req_addr[1:0] == 2'b11); end
         2'b10: begin w_size_mask = 4'b1111; w_split = (i_req_addr[1:0] != 2'b00); end
         default: begin w_size_mask = 4'b1111; w_split = 1'b0; end
      endcase
      w_strb8 = {4'b0000, w_size_mask} << i_req_addr[1:0];
   end

   // Store data as a 64-bit lane image: low word is beat0, high word is beat1.
   always_comb begin
      case (i_req_addr[1:0])
         2'b00: begin w_wdata_lo = i_req_wdata;                 w_wdata_hi = 32'd0; end
         2'b01: begin w_wdata_lo = {i_req_wdata[23:0], 8'd0};   w_wdata_hi = {24'd0, i_req_wdata[31:24]}; end
         2'b10: begin w_wdata_lo = {i_req_wdata[15:0], 16'd0};  w_wdata_hi = {16'd0, i_req_wdata[31:16]}; end
         2'b11: begin w_wdata_lo = {i_req_wdata[7:0], 24'd0};   w_wdata_hi = {8'd0, i_req_wdata[31:8]}; end
         default: begin w_wdata_lo = 32'd0; w_wdata_hi = 32'd0; end
      endcase
   end

   // Load merge: the final beat's data is used live, beat0 comes from r_rd0.
   always_comb begin
      case (r_state)
         S_B0_WAIT: begin w_rd_lo = i_bus_rdata; w_rd_hi = 24'd0; end
         S_B1_WAIT: begin w_rd_lo = r_rd0;       w_rd_hi = i_bus_rdata[23:0]; end
         default:   begin w_rd_lo = 32'd0;       w_rd_hi = 24'd0; end
      endcase
      case (r_off)
         2'b00:   w_stream = w_rd_lo;
         2'b01:   w_stream = {w_rd_hi[7:0],  w_rd_lo[31:8]};
         2'b10:   w_stream = {w_rd_hi[15:0], w_rd_lo[31:16]};
         2'b11:   w_stream = {w_rd_hi[23:0], w_rd_lo[31:24]};
         default: w_stream = w_rd_lo;
      endcase
      w_load = load_extend(w_stream, r_funct3);
   end

   // Sequencer FSM with registered bus and response outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_split     <= 1'b0;
         r_off       <= 2'b00;
         r_funct3    <= 3'b000;
         r_addr1     <= '0;
         r_wdata_hi  <= 32'd0;
         r_wstrb_hi  <= 4'b0000;
         r_rd0       <= 32'd0;
         r_bus_valid <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wstrb <= 4'b0000;
         r_bus_wdata <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we       <= i_req_mem_w;
                  r_split    <= w_split;
                  r_off      <= i_req_addr[1:0];
                  r_funct3   <= i_req_funct3;
                  r_addr1    <= w_addr0 + ADDR_W'(32'd4);
                  r_wdata_hi <= w_wdata_hi;
                  r_wstrb_hi <= w_strb8[7:4];
                  if (w_illegal) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= 32'd0;
                  end else begin
                     r_state     <= S_B0_REQ;
                     r_bus_valid <= 1'b1;
                     r_bus_we    <= i_req_mem_w;
                     r_bus_addr  <= w_addr0;
                     r_bus_wstrb <= i_req_mem_w ? w_strb8[3:0] : 4'b0000;
                     r_bus_wdata <= i_req_mem_w ? w_wdata_lo : 32'd0;
                  end
               end
            end
            S_B0_REQ: begin
               if (i_bus_ready) begin
                  if (r_we && r_split) begin
                     // Second store beat follows immediately on the bus.
                     r_state     <= S_B1_REQ;
                     r_bus_addr  <= r_addr1;
                     r_bus_wstrb <= r_wstrb_hi;
                     r_bus_wdata <= r_wdata_hi;
                  end else begin
                     r_state     <= r_we ? S_RESP : S_B0_WAIT;
                     r_rsp_valid <= r_we;
                     r_rsp_rdata <= 32'd0;
                     r_bus_valid <= 1'b0;
                     r_bus_we    <= 1'b0;
                     r_bus_addr  <= '0;
                     r_bus_wstrb <= 4'b0000;
                     r_bus_wdata <= 32'd0;
                  end
               end
            end
            S_B0_WAIT: begin
               if (i_bus_rvalid) begin
                  r_rd0 <= i_bus_rdata;
                  if (r_split) begin
                     r_state     <= S_B1_REQ;
                     r_bus_valid <= 1'b1;
                     r_bus_addr  <= r_addr1;
                  end else begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= w_load;
                  end
               end
            end
            S_B1_REQ: begin
               if (i_bus_ready) begin
                  r_state     <= r_we ? S_RESP : S_B1_WAIT;
                  r_rsp_valid <= r_we;
                  r_rsp_rdata <= 32'd0;
                  r_bus_valid <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_addr  <= '0;
                  r_bus_wstrb <= 4'b0000;
                  r_bus_wdata <= 32'd0;
               end
            end
            S_B1_WAIT: begin
               if (i_bus_rvalid) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_load;
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= 32'd0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_bus_valid <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: a scripted bus responder plus per-feature
// tasks comparing latency, beats and response data against hand-computed values.
module tb_lsu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_mem_r = 1'b0;
   logic        req_mem_w = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ready = 1'b1;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   int n_tests = 0;
   int n_fail = 0;
   int g_lat, g_nbeats, g_stall_cnt, g_unstable;
   logic [31:0] g_rdata;
   logic        g_err;
   logic [31:0] b_addr [4];
   logic [3:0]  b_strb [4];
   logic [31:0] b_wdata [4];
   logic        b_we [4];

   always #5 clk = ~clk;

   lsu_sequencer #(.ADDR_W(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_mem_r(req_mem_r), .i_req_mem_w(req_mem_w), .i_req_funct3(req_funct3),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_stall(stall),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .o_bus_valid(bus_valid), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
      .o_bus_wstrb(bus_wstrb), .o_bus_wdata(bus_wdata), .i_bus_ready(bus_ready),
      .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'hDEAD_BEEF;
         32'h0000_0200: return 32'h8011_2233;
         32'h0000_1000: return 32'h4433_2211;
         32'h0000_1004: return 32'h8877_6655;
         32'hFFFF_FFFC: return 32'hAABB_CCDD;
         32'h0000_0000: return 32'h1122_3344;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   // One access with a scripted bus: ready held low 'hold' cycles on beat0, rvalid one cycle after read acceptance.
   task automatic run_access(input logic mr, input logic mw, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input int hold);
      int hold_left;
      logic pend;
      logic [31:0] pend_addr, snap_addr, snap_wdata;
      hold_left = hold; pend = 1'b0; pend_addr = 32'd0; snap_addr = 32'd0; snap_wdata = 32'd0;
      g_lat = -1; g_nbeats = 0; g_stall_cnt = 0; g_unstable = 0; g_rdata = 32'd0; g_err = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_mem_r = mr; req_mem_w = mw; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; bus_ready = 1'b1; bus_rvalid = 1'b0;
      #1;
      if (stall) g_stall_cnt++;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (stall) g_stall_cnt++;
         if (rsp_valid) begin
            g_lat = c; g_rdata = rsp_rdata; g_err = rsp_err;
            req_valid = 1'b0; bus_rvalid = 1'b0;
            break;
         end
         bus_rvalid = pend;
         bus_rdata  = pend ? mem_word(pend_addr) : 32'd0;
         pend = 1'b0;
         if (bus_valid) begin
            if (hold_left > 0) begin
               if (hold_left == hold) begin
                  snap_addr = bus_addr; snap_wdata = bus_wdata;
               end else if (bus_addr !== snap_addr || bus_wdata !== snap_wdata) begin
                  g_unstable++;
               end
               bus_ready = 1'b0;
               hold_left--;
            end else begin
               if (hold > 0 && g_nbeats == 0 && (bus_addr !== snap_addr || bus_wdata !== snap_wdata))
                  g_unstable++;
               bus_ready = 1'b1;
               if (g_nbeats < 4) begin
                  b_addr[g_nbeats] = bus_addr; b_strb[g_nbeats] = bus_wstrb;
                  b_wdata[g_nbeats] = bus_wdata; b_we[g_nbeats] = bus_we;
               end
               g_nbeats++;
               if (!bus_we) begin pend = 1'b1; pend_addr = bus_addr; end
            end
         end else begin
            bus_ready = 1'b1;
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
      n_tests++; if ({bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata} !== 70'd0) begin n_fail++;
         $display("FAIL reset_bus: got valid=%b we=%b strb=%h addr=%h wdata=%h expected all 0", bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata); end
      n_tests++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin n_fail++;
         $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h expected all 0", rsp_valid, rsp_err, rsp_rdata); end
   endtask

   task automatic test_aligned_load();
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0);
      n_tests++; if (g_lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d expected 3", g_lat); end
      n_tests++; if (g_rdata !== 32'hDEADBEEF || g_err !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h err=%b expected deadbeef err=0", g_rdata, g_err); end
      n_tests++; if (g_nbeats !== 1 || b_addr[0] !== 32'h100 || b_strb[0] !== 4'b0000 || b_we[0] !== 1'b0) begin n_fail++;
         $display("FAIL lw_beat: got n=%0d addr=%h strb=%b we=%b expected n=1 addr=100 strb=0000 we=0", g_nbeats, b_addr[0], b_strb[0], b_we[0]); end
      n_tests++; if (g_stall_cnt !== 3) begin n_fail++; $display("FAIL lw_stall: got %0d stall cycles expected 3", g_stall_cnt); end
   endtask

   task automatic test_load_extend();
      logic [2:0] f3; logic [31:0] a, e;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin f3 = 3'b000; a = 32'h203; e = 32'hFFFFFF80; end
            1: begin f3 = 3'b100; a = 32'h203; e = 32'h00000080; end
            2: begin f3 = 3'b001; a = 32'h202; e = 32'hFFFF8011; end
            default: begin f3 = 3'b101; a = 32'h202; e = 32'h00008011; end
         endcase
         run_access(1'b1, 1'b0, f3, a, 32'd0, 0);
         n_tests++; if (g_rdata !== e || g_lat !== 3 || b_addr[0] !== 32'h200) begin n_fail++;
            $display("FAIL load_ext_%0d: got data=%h lat=%0d addr=%h expected data=%h lat=3 addr=200", k, g_rdata, g_lat, b_addr[0], e); end
      end
   endtask

   task automatic test_split_load();
      run_access(1'b1, 1'b0, 3'b010, 32'h1001, 32'd0, 0);
      n_tests++; if (g_rdata !== 32'h55443322 || g_lat !== 5) begin n_fail++; $display("FAIL split_lw: got data=%h lat=%0d expected 55443322 lat=5", g_rdata, g_lat); end
      n_tests++; if (g_nbeats !== 2 || b_addr[0] !== 32'h1000 || b_addr[1] !== 32'h1004) begin n_fail++;
         $display("FAIL split_lw_beats: got n=%0d a0=%h a1=%h expected n=2 a0=1000 a1=1004", g_nbeats, b_addr[0], b_addr[1]); end
      n_tests++; if (g_stall_cnt !== 5) begin n_fail++; $display("FAIL split_lw_stall: got %0d expected 5", g_stall_cnt); end
      run_access(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0);
      n_tests++; if (b_addr[0] !== 32'hFFFFFFFC || b_addr[1] !== 32'h0 || g_rdata !== 32'h3344AABB) begin n_fail++;
         $display("FAIL wrap_lw: got a0=%h a1=%h data=%h expected a0=fffffffc a1=00000000 data=3344aabb", b_addr[0], b_addr[1], g_rdata); end
      run_access(1'b1, 1'b0, 3'b001, 32'h1003, 32'd0, 0);
      n_tests++; if (g_rdata !== 32'h00005544 || g_lat !== 5) begin n_fail++; $display("FAIL split_lh: got data=%h lat=%0d expected 00005544 lat=5", g_rdata, g_lat); end
   endtask

   task automatic test_split_store();
      run_access(1'b0, 1'b1, 3'b001, 32'h3003, 32'h1234ABCD, 0);
      n_tests++; if (g_lat !== 3 || g_nbeats !== 2 || g_rdata !== 32'd0) begin n_fail++; $display("FAIL sh_split_lat: got lat=%0d n=%0d data=%h expected lat=3 n=2 data=0", g_lat, g_nbeats, g_rdata); end
      n_tests++; if (b_addr[0] !== 32'h3000 || b_strb[0] !== 4'b1000 || b_wdata[0][31:24] !== 8'hCD || b_we[0] !== 1'b1) begin n_fail++;
         $display("FAIL sh_beat0: got addr=%h strb=%b byte=%h we=%b expected 3000 1000 cd 1", b_addr[0], b_strb[0], b_wdata[0][31:24], b_we[0]); end
      n_tests++; if (b_addr[1] !== 32'h3004 || b_strb[1] !== 4'b0001 || b_wdata[1][7:0] !== 8'hAB || b_we[1] !== 1'b1) begin n_fail++;
         $display("FAIL sh_beat1: got addr=%h strb=%b byte=%h we=%b expected 3004 0001 ab 1", b_addr[1], b_strb[1], b_wdata[1][7:0], b_we[1]); end
      run_access(1'b0, 1'b1, 3'b010, 32'h2002, 32'hAABBCCDD, 0);
      n_tests++; if (b_strb[0] !== 4'b1100 || b_wdata[0][31:16] !== 16'hCCDD || b_strb[1] !== 4'b0011 || b_wdata[1][15:0] !== 16'hAABB) begin n_fail++;
         $display("FAIL sw_split: got s0=%b d0=%h s1=%b d1=%h expected s0=1100 d0[31:16]=ccdd s1=0011 d1[15:0]=aabb", b_strb[0], b_wdata[0], b_strb[1], b_wdata[1]); end
   endtask

   task automatic test_store_ready_stall();
      run_access(1'b0, 1'b1, 3'b000, 32'h501, 32'h0000005A, 0);
      n_tests++; if (g_lat !== 2 || b_strb[0] !== 4'b0010 || b_wdata[0][15:8] !== 8'h5A || b_addr[0] !== 32'h500) begin n_fail++;
         $display("FAIL sb: got lat=%0d strb=%b data=%h addr=%h expected lat=2 strb=0010 data[15:8]=5a addr=500", g_lat, b_strb[0], b_wdata[0], b_addr[0]); end
      run_access(1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 3);
      n_tests++; if (g_lat !== 5) begin n_fail++; $display("FAIL ready_low_latency: got %0d expected 5", g_lat); end
      n_tests++; if (g_unstable !== 0) begin n_fail++; $display("FAIL ready_low_stable: got %0d changes expected 0", g_unstable); end
      n_tests++; if (g_nbeats !== 1 || b_strb[0] !== 4'b1111 || b_wdata[0] !== 32'h12345678 || b_addr[0] !== 32'h400) begin n_fail++;
         $display("FAIL sw_beat: got n=%0d strb=%b data=%h addr=%h expected n=1 strb=1111 data=12345678 addr=400", g_nbeats, b_strb[0], b_wdata[0], b_addr[0]); end
   endtask

   task automatic test_spurious_rvalid();
      int bad;
      bad = 0;
      @(negedge clk);
      req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || bus_valid !== 1'b0 || req_ready !== 1'b1) bad++;
      end
      bus_rvalid = 1'b0;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL spurious_rvalid_idle: got %0d bad cycles expected 0", bad); end
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0);
      n_tests++; if (g_rdata !== 32'hDEADBEEF || g_lat !== 3) begin n_fail++; $display("FAIL after_spurious: got data=%h lat=%0d expected deadbeef lat=3", g_rdata, g_lat); end
   endtask

   task automatic test_illegal();
      logic mr, mw; logic [2:0] f3;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: begin mr = 1'b1; mw = 1'b0; f3 = 3'b011; end
            1: begin mr = 1'b1; mw = 1'b0; f3 = 3'b110; end
            2: begin mr = 1'b0; mw = 1'b1; f3 = 3'b011; end
            default: begin mr = 1'b1; mw = 1'b1; f3 = 3'b010; end
         endcase
         run_access(mr, mw, f3, 32'h100, 32'hFFFFFFFF, 0);
         n_tests++; if (g_lat !== 1 || g_err !== 1'b1 || g_nbeats !== 0 || g_rdata !== 32'd0 || g_stall_cnt !== 1) begin n_fail++;
            $display("FAIL illegal_%0d: got lat=%0d err=%b beats=%0d data=%h stall=%0d expected lat=1 err=1 beats=0 data=0 stall=1", k, g_lat, g_err, g_nbeats, g_rdata, g_stall_cnt); end
      end
   endtask

   task automatic test_reset_midflight();
      int seen;
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_mem_r = 1'b1; req_mem_w = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
      bus_ready = 1'b1; bus_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall: got %b expected 1", stall); end
      rst_n = 1'b0; req_valid = 1'b0;
      #1;
      n_tests++; if (bus_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin n_fail++;
         $display("FAIL rst_in_wait: got valid=%b ready=%b stall=%b expected 0 1 0", bus_valid, req_ready, stall); end
      @(negedge clk);
      rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      repeat (4) begin
         @(negedge clk);
         bus_rvalid = 1'b0;
         if (rsp_valid !== 1'b0) seen++;
      end
      n_tests++; if (seen !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_no_rsp: got %0d rsp pulses ready=%b expected 0 and 1", seen, req_ready); end
      req_valid = 1'b1; bus_ready = 1'b0;
      @(negedge clk);
      n_tests++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL b0_req_valid: got %b expected 1", bus_valid); end
      rst_n = 1'b0; req_valid = 1'b0;
      #1;
      n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_req: got bus_valid=%b expected 0", bus_valid); end
      @(negedge clk);
      rst_n = 1'b1; bus_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_aligned_load();
      test_load_extend();
      test_split_load();
      test_split_store();
      test_store_ready_stall();
      test_spurious_rvalid();
      test_illegal();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Load/store sequencer between the execute stage and the data-memory bus. Accepts one access per request when MemR or MemW is set, issues one or two word-aligned bus beats, merges and sign/zero-extends load data per load_type_t, and stalls the pipeline until a one-cycle response. Misaligned accesses that cross a word boundary are split into two beats. Illegal encodings return an error without touching the bus.

## Interface
- ADDR_W, 32, byte address width; data path is fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents an access; held stable until rsp_valid.
- req_ready  out  1  high only in IDLE.
- req_mem_r  in  1  MemR from bundle_decode_t.
- req_mem_w  in  1  MemW from bundle_decode_t.
- req_funct3  in  3  load: load_type_t; store: 000 byte, 001 half, 010 word.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2), low bytes used.
- stall  out  1  freeze upstream stages.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; illegal access.
- bus_valid, bus_we  out  1  bus request, write enable.
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- bus_wstrb  out  4  byte-lane strobes; 0 on reads.
- bus_wdata  out  32  lane-aligned write data.
- bus_ready  in  1  request accepted when bus_valid & bus_ready.
- bus_rvalid  in  1  read data valid, ≥1 cycle after read acceptance.
- bus_rdata  in  32  read data.

## Operation
- States: IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP.
- Acceptance: req_valid & req_ready & (req_mem_r | req_mem_w). Address, funct3, wdata, direction are latched.
- Illegal: both MemR and MemW set; load funct3 ∈ {011,110,111}; store funct3 > 010. IDLE→RESP with rsp_err=1 and no bus activity.
- Size is 1/2/4 bytes and offset = addr[1:0]. Split when offset+size > 4. Beat0 goes to {addr[31:2],00}; beat1 goes to beat0+4, modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000.
- Store lanes: data shifted left by 8·offset. Beat0 carries lanes offset..3. Beat1 carries the remaining low lanes, 0..(offset+size−5), with data shifted right by 8·(4−offset).
- Load merge: byte stream = {beat1_rdata, beat0_rdata} >> 8·offset, truncated to size. Signed types sign-extend from bit 7/15; unsigned types zero-extend.
- Transitions:
  - IDLE→B0_REQ on legal acceptance.
  - B0_REQ on handshake: write → B1_REQ if split, else RESP; read → B0_WAIT.
  - B0_WAIT on bus_rvalid → B1_REQ if split, else RESP.
  - B1_REQ and B1_WAIT follow the same pattern and end in RESP.
  - RESP→IDLE unconditionally.
- bus_valid is high only in B*_REQ. bus_addr, bus_we, bus_wstrb and bus_wdata stay stable while bus_valid & ~bus_ready.
- bus_rvalid outside B*_WAIT is ignored.
- stall = (state ∉ {IDLE, RESP}) | (state==IDLE & req_valid & (req_mem_r|req_mem_w)).

## Timing
- Reset (async, immediate): state IDLE; bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata = 0; rsp_valid, rsp_err, rsp_rdata = 0; req_ready=1; stall=0.
- Reset mid-transaction drops bus_valid immediately and discards the access. No response is produced.
- Outputs are registered from state or latched fields, except stall and req_ready, which are decoded combinationally.
- Minimum latency from acceptance cycle T, with bus_ready=1 and rvalid one cycle after acceptance:
  - aligned load: rsp_valid at T+3;
  - aligned store: T+2;
  - split load: T+5;
  - split store: T+3;
  - illegal: T+1.
- Each cycle of bus_ready low or rvalid delay adds one cycle.
- A new request can be accepted in the cycle after RESP.

## Test plan
- Aligned LW at 0x100, bus_rdata=0xDEADBEEF → one beat at addr 0x100, wstrb 0000; rsp_valid at T+3 with 0xDEADBEEF; stall high T..T+2.
- LB at 0x203 with word 0x80112233 → 0xFFFFFF80. Same access as LBU → 0x00000080. LH at 0x202 → 0xFFFF8011.
- Split LW at 0x1001, words 0x44332211 at 0x1000 and 0x88776655 at 0x1004 → two beats, rsp_rdata 0x55443322. LW at 0xFFFFFFFE → beat1 address 0x00000000.
- SH 0xABCD at 0x3003 → beat0 addr 0x3000, wstrb 1000, wdata[31:24]=0xCD; beat1 addr 0x3004, wstrb 0001, wdata[7:0]=0xAB; rsp_valid T+3.
- bus_ready held low 3 cycles in B0_REQ → bus_valid, addr and wdata stable; latency +3. Spurious rvalid in IDLE is ignored.
- Funct3=011 load → rsp_err=1, no bus_valid, rsp_valid at T+1. rst_n low during B0_WAIT → bus_valid=0 at once, no rsp_valid, req_ready=1 after release.
